// File: rtl/altera_tse_lvds_tbi_tx_framer_pkg.sv
// TBI transmit framer shared definitions: 8b/10b code groups in a..j order,
// the framer state encoding and a bit-reverse helper for the ALTLVDS lane.
package altera_tse_lvds_tbi_tx_framer_pkg;

    localparam logic [9:0] K28_5_N = 10'h17C;
    localparam logic [9:0] K28_5_P = 10'h283;
    localparam logic [9:0] D16_2_P = 10'h289;
    localparam logic [9:0] D5_6    = 10'h1A5;
    localparam logic [9:0] K30_7_N = 10'h05E;
    localparam logic [9:0] K30_7_P = 10'h3A1;
    localparam logic [9:0] K23_7_N = 10'h057;
    localparam logic [9:0] K23_7_P = 10'h3A8;

    typedef enum logic [1:0] {
        ST_IDLE_K = 2'd0,
        ST_IDLE_D = 2'd1,
        ST_DATA   = 2'd2,
        ST_EXT    = 2'd3
    } tx_state_e;

    function automatic logic [9:0] bitrev10(input logic [9:0] w);
        logic [9:0] r;
        for (int i = 0; i < 10; i++) begin
            r[i] = w[9-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/altera_tse_tbi_disparity.sv
// Ones-count of a 10-bit code group and the resulting running disparity.
// Ports: i_word, i_rd (1 = RD+) in; o_rd next RD, o_err disparity/format error.
module altera_tse_tbi_disparity (
    input  logic [9:0] i_word,
    input  logic       i_rd,
    output logic       o_rd,
    output logic       o_err
);

    logic [3:0] w_ones;

    always_comb begin
        w_ones = 4'd0;
        for (int i = 0; i < 10; i++) begin
            w_ones = w_ones + {3'b000, i_word[i]};
        end
    end

    // A 6-ones word at RD+ (or 4-ones at RD-) is flagged but still moves RD.
    always_comb begin
        o_rd  = i_rd;
        o_err = 1'b0;
        case (w_ones)
            4'd4: begin
                o_rd  = 1'b0;
                o_err = ~i_rd;
            end
            4'd5: begin
                o_rd  = i_rd;
            end
            4'd6: begin
                o_rd  = 1'b1;
                o_err = i_rd;
            end
            default: begin
                o_err = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/altera_tse_lvds_tbi_tx_framer.sv
// TBI transmit framer: inserts /I1/,/I2/ idles, /V/ on underrun, /R/ pad.
// Ports: i_clk, i_rst, i_tx_valid/i_tx_data/i_tx_last, o_tx_ready,
// o_tbi_tx (bit-reversed), o_idle_active, o_rd_pos, o_disp_err, o_underrun.
module altera_tse_lvds_tbi_tx_framer
    import altera_tse_lvds_tbi_tx_framer_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_tx_valid,
    input  logic [9:0] i_tx_data,
    input  logic       i_tx_last,
    output logic       o_tx_ready,
    output logic [9:0] o_tbi_tx,
    output logic       o_idle_active,
    output logic       o_rd_pos,
    output logic       o_disp_err,
    output logic       o_underrun
);

    tx_state_e  r_state;
    logic       r_pos;
    logic       r_rd;
    logic [9:0] r_tbi;
    logic       r_idle;
    logic       r_derr;
    logic       r_und;

    tx_state_e  w_next;
    logic [9:0] w_word;
    logic       w_idle;
    logic       w_und;
    logic       w_acc;
    logic       w_rd_nxt;
    logic       w_err;

    altera_tse_tbi_disparity u_disp (
        .i_word (w_word),
        .i_rd   (r_rd),
        .o_rd   (w_rd_nxt),
        .o_err  (w_err)
    );

    always_comb begin
        w_next = r_state;
        w_word = K28_5_N;
        w_idle = 1'b0;
        w_und  = 1'b0;
        w_acc  = 1'b0;
        unique case (r_state)
            ST_IDLE_K: begin
                w_word = r_rd ? K28_5_P : K28_5_N;
                w_idle = 1'b1;
                w_next = ST_IDLE_D;
            end
            ST_IDLE_D: begin
                // K28.5 always flips RD, so RD+ now means RD- before it.
                w_word = r_rd ? D16_2_P : D5_6;
                w_idle = 1'b1;
                w_next = i_tx_valid ? ST_DATA : ST_IDLE_K;
            end
            ST_DATA: begin
                if (i_tx_valid) begin
                    w_word = i_tx_data;
                    w_acc  = 1'b1;
                    if (i_tx_last) begin
                        w_next = r_pos ? ST_IDLE_K : ST_EXT;
                    end
                end else begin
                    w_word = r_rd ? K30_7_P : K30_7_N;
                    w_und  = 1'b1;
                end
            end
            ST_EXT: begin
                // Pad one word so the next comma lands on an even position.
                w_word = r_rd ? K23_7_P : K23_7_N;
                w_idle = 1'b1;
                w_next = ST_IDLE_K;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE_K;
            r_pos   <= 1'b0;
            r_rd    <= 1'b0;
            r_tbi   <= 10'h000;
            r_idle  <= 1'b0;
            r_derr  <= 1'b0;
            r_und   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_pos   <= ~r_pos;
            r_rd    <= w_rd_nxt;
            r_tbi   <= bitrev10(w_word);
            r_idle  <= w_idle;
            r_derr  <= w_err & w_acc;
            r_und   <= w_und;
        end
    end

    assign o_tx_ready    = (r_state == ST_DATA);
    assign o_tbi_tx      = r_tbi;
    assign o_idle_active = r_idle;
    assign o_rd_pos      = r_rd;
    assign o_disp_err    = r_derr;
    assign o_underrun    = r_und;

endmodule

// File: tb/tb_altera_tse_lvds_tbi_tx_framer.sv
// Scoreboard bench for the TBI transmit framer.
// Expected words are queued at drive time and compared one edge later.
module tb_altera_tse_lvds_tbi_tx_framer;

    logic       clk;
    logic       rst;
    logic       tx_valid;
    logic [9:0] tx_data;
    logic       tx_last;
    logic       tx_ready;
    logic [9:0] tbi_tx;
    logic       idle_active;
    logic       rd_pos;
    logic       disp_err;
    logic       underrun;

    altera_tse_lvds_tbi_tx_framer dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_tx_valid    (tx_valid),
        .i_tx_data     (tx_data),
        .i_tx_last     (tx_last),
        .o_tx_ready    (tx_ready),
        .o_tbi_tx      (tbi_tx),
        .o_idle_active (idle_active),
        .o_rd_pos      (rd_pos),
        .o_disp_err    (disp_err),
        .o_underrun    (underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [9:0] tbi;
        logic       idle;
        logic       rd;
        logic       derr;
        logic       und;
    } exp_t;

    localparam int S_K = 0;
    localparam int S_D = 1;
    localparam int S_DATA = 2;
    localparam int S_EXT = 3;

    exp_t q[$];
    int n_vec = 0;
    int n_mis = 0;
    int m_st = S_K;
    logic m_pos = 1'b0;
    logic m_rd = 1'b0;
    logic [9:0] fw[16];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [9:0] rev(input logic [9:0] w);
        logic [9:0] r;
        for (int i = 0; i < 10; i++) r[i] = w[9-i];
        return r;
    endfunction

    task automatic model_reset();
        m_st = S_K;
        m_pos = 1'b0;
        m_rd = 1'b0;
        q.delete();
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic step(input logic v, input logic [9:0] d, input logic l,
                        output logic acc);
        exp_t e;
        exp_t g;
        logic [9:0] w;
        int n;
        int nx;
        logic a;
        tx_valid = v;
        tx_data = d;
        tx_last = l;
        check("tx_ready", 32'(tx_ready), 32'(m_st == S_DATA));
        e = '0;
        a = 1'b0;
        nx = m_st;
        case (m_st)
            S_K: begin
                w = m_rd ? 10'h283 : 10'h17C;
                e.idle = 1'b1;
                nx = S_D;
            end
            S_D: begin
                w = m_rd ? 10'h289 : 10'h1A5;
                e.idle = 1'b1;
                nx = v ? S_DATA : S_K;
            end
            S_DATA: begin
                if (v) begin
                    w = d;
                    a = 1'b1;
                    if (l) nx = m_pos ? S_K : S_EXT;
                end else begin
                    w = m_rd ? 10'h3A1 : 10'h05E;
                    e.und = 1'b1;
                end
            end
            default: begin
                w = m_rd ? 10'h3A8 : 10'h057;
                e.idle = 1'b1;
                nx = S_K;
            end
        endcase
        n = $countones(w);
        if (a && ((n == 6 && m_rd) || (n == 4 && !m_rd) || n < 4 || n > 6))
            e.derr = 1'b1;
        if (n == 6) m_rd = 1'b1;
        else if (n == 4) m_rd = 1'b0;
        e.rd = m_rd;
        e.tbi = rev(w);
        q.push_back(e);
        m_st = nx;
        m_pos = ~m_pos;
        acc = a;
        @(posedge clk);
        #1;
        if (q.size() == 0) begin
            check("sb_empty", 32'(1), 32'(0));
        end else begin
            g = q.pop_front();
            check("tbi_tx", 32'(tbi_tx), 32'(g.tbi));
            check("idle_active", 32'(idle_active), 32'(g.idle));
            check("rd_pos", 32'(rd_pos), 32'(g.rd));
            check("disp_err", 32'(disp_err), 32'(g.derr));
            check("underrun", 32'(underrun), 32'(g.und));
        end
        @(negedge clk);
    endtask

    task automatic idle_cycles(input int n);
        logic acc;
        for (int i = 0; i < n; i++) step(1'b0, 10'h000, 1'b0, acc);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_tbi_async", 32'(tbi_tx), 32'(10'h000));
        check("rst_ready_async", 32'(tx_ready), 32'(0));
        check("rst_idle", 32'(idle_active), 32'(0));
        check("rst_rd", 32'(rd_pos), 32'(0));
        check("rst_derr", 32'(disp_err), 32'(0));
        check("rst_und", 32'(underrun), 32'(0));
        tx_valid = 1'b0;
        tx_last = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic send_frame(input int len, input int gap_at,
                              input int gap_len, input int rst_at);
        int idx;
        int gd;
        int guard;
        logic acc;
        idx = 0;
        gd = 0;
        guard = 0;
        while (idx < len) begin
            if (rst_at >= 0 && idx == rst_at && m_st == S_DATA) begin
                do_reset();
                return;
            end
            if (m_st == S_DATA && idx == gap_at && gd < gap_len) begin
                step(1'b0, 10'h000, 1'b0, acc);
                gd++;
                check("gap_underrun", 32'(underrun), 32'(1));
            end else begin
                step(1'b1, fw[idx], 1'(idx == len - 1), acc);
                if (acc) begin
                    if (fw[idx] == 10'h3F0) begin
                        check("bad_rd_err", 32'(disp_err), 32'(1));
                        check("bad_rd_word", 32'(tbi_tx), 32'(rev(10'h3F0)));
                        check("bad_rd_rd", 32'(rd_pos), 32'(1));
                    end
                    idx++;
                end
            end
            guard++;
            if (guard > 200) begin
                check("frame_timeout", 32'(1), 32'(0));
                return;
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        tx_valid = 1'b0;
        tx_data = 10'h000;
        tx_last = 1'b0;
        @(negedge clk);
        check("reset_tbi", 32'(tbi_tx), 32'(10'h000));
        check("reset_ready", 32'(tx_ready), 32'(0));
        check("reset_rd", 32'(rd_pos), 32'(0));
        check("reset_idle", 32'(idle_active), 32'(0));
        rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            idle_cycles(1);
            if (i % 2 == 0) begin
                check("idle_k", 32'(tbi_tx), 32'(10'h0FA));
                check("idle_k_rd", 32'(rd_pos), 32'(1));
            end else begin
                check("idle_i2", 32'(tbi_tx), 32'(10'h245));
                check("idle_i2_rd", 32'(rd_pos), 32'(0));
            end
        end

        for (int i = 0; i < 4; i++) fw[i] = 10'h2AA;
        send_frame(4, -1, 0, -1);
        idle_cycles(6);
        send_frame(3, -1, 0, -1);
        idle_cycles(6);

        for (int i = 0; i < 5; i++) fw[i] = 10'h2AA;
        send_frame(5, 2, 2, -1);
        idle_cycles(6);

        fw[0] = 10'h0FC;
        fw[1] = 10'h3F0;
        fw[2] = 10'h3FF;
        fw[3] = 10'h2AA;
        send_frame(4, -1, 0, -1);
        idle_cycles(6);

        for (int r = 0; r < 6; r++) begin
            int len;
            len = $urandom_range(1, 8);
            for (int i = 0; i < len; i++) fw[i] = 10'($urandom);
            send_frame(len, $urandom_range(0, len), $urandom_range(0, 2), -1);
            idle_cycles($urandom_range(1, 5));
        end

        for (int i = 0; i < 6; i++) fw[i] = 10'h2AA;
        send_frame(6, -1, 0, 2);
        idle_cycles(1);
        check("post_rst_k", 32'(tbi_tx), 32'(10'h0FA));
        idle_cycles(6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
